// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks pending register-file writes per architectural
// register and holds issue off on RAW/WAW hazards until writeback releases them.
module reg_scoreboard #(
  parameter int unsigned NREGS   = 32,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned STALL_W = 32,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               iss_valid,
  output logic               iss_ready,
  input  logic [AW-1:0]      iss_rs1,
  input  logic               iss_rs1_used,
  input  logic [AW-1:0]      iss_rs2,
  input  logic               iss_rs2_used,
  input  logic               iss_rd0_en,
  input  logic [AW-1:0]      iss_rd0,
  input  logic               iss_rd1_en,
  input  logic [AW-1:0]      iss_rd1,
  input  logic               wb0_en,
  input  logic [AW-1:0]      wb0_addr,
  input  logic               wb1_en,
  input  logic [AW-1:0]      wb1_addr,
  input  logic               flush,
  output logic [NREGS-1:0]   busy_mask,
  output logic [STALL_W-1:0] stall_cycles,
  output logic               underflow_err
);

  logic [CNT_W-1:0] pend_q [NREGS];
  logic [CNT_W-1:0] pend_d [NREGS];
  logic [NREGS-1:0] busy_d;
  logic             hazard;
  logic             fire;
  logic             under_set;

  // pend_q[0] is held at zero, so r0 never raises a hazard.
  always_comb begin
    hazard = 1'b0;
    if (iss_rs1_used && iss_rs1 != '0 && pend_q[iss_rs1] != '0) hazard = 1'b1;
    if (iss_rs2_used && iss_rs2 != '0 && pend_q[iss_rs2] != '0) hazard = 1'b1;
    if (iss_rd0_en && iss_rd0 != '0 && pend_q[iss_rd0] != '0) hazard = 1'b1;
    if (iss_rd1_en && iss_rd1 != '0 && pend_q[iss_rd1] != '0) hazard = 1'b1;
    if (iss_rd0_en && pend_q[iss_rd0] == '1) hazard = 1'b1;
    if (iss_rd1_en && pend_q[iss_rd1] == '1) hazard = 1'b1;
  end

  assign iss_ready = !flush && !hazard;
  assign fire      = iss_valid && iss_ready;

  // Matching rd0/rd1 (or wb0/wb1) addresses collapse into a single event per register.
  always_comb begin
    logic inc;
    logic dec;
    under_set = 1'b0;
    busy_d    = '0;
    pend_d[0] = '0;
    for (int unsigned i = 1; i < NREGS; i++) begin
      inc = fire && ((iss_rd0_en && iss_rd0 == AW'(i)) || (iss_rd1_en && iss_rd1 == AW'(i)));
      dec = (wb0_en && wb0_addr == AW'(i)) || (wb1_en && wb1_addr == AW'(i));
      pend_d[i] = pend_q[i];
      if (flush) begin
        pend_d[i] = '0;
      end else if (inc && !dec) begin
        pend_d[i] = pend_q[i] + CNT_W'(1);
      end else if (dec && !inc) begin
        if (pend_q[i] == '0) under_set = 1'b1;
        else                 pend_d[i] = pend_q[i] - CNT_W'(1);
      end
      busy_d[i] = (pend_d[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q        <= '{default: '0};
      busy_mask     <= '0;
      stall_cycles  <= '0;
      underflow_err <= 1'b0;
    end else begin
      pend_q        <= pend_d;
      busy_mask     <= busy_d;
      underflow_err <= underflow_err | under_set;
      if (iss_valid && !iss_ready && stall_cycles != '1)
        stall_cycles <= stall_cycles + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid, iss_ready;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd0, iss_rd1, wb0_addr, wb1_addr;
  logic        iss_rs1_used, iss_rs2_used, iss_rd0_en, iss_rd1_en;
  logic        wb0_en, wb1_en, flush;
  logic [31:0] busy_mask;
  logic [31:0] stall_cycles;
  logic        underflow_err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  reg_scoreboard #(.NREGS(32), .CNT_W(2), .STALL_W(32)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs1_used(iss_rs1_used),
    .iss_rs2(iss_rs2), .iss_rs2_used(iss_rs2_used),
    .iss_rd0_en(iss_rd0_en), .iss_rd0(iss_rd0),
    .iss_rd1_en(iss_rd1_en), .iss_rd1(iss_rd1),
    .wb0_en(wb0_en), .wb0_addr(wb0_addr),
    .wb1_en(wb1_en), .wb1_addr(wb1_addr),
    .flush(flush), .busy_mask(busy_mask),
    .stall_cycles(stall_cycles), .underflow_err(underflow_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    iss_valid = 0; iss_rs1 = 0; iss_rs1_used = 0; iss_rs2 = 0; iss_rs2_used = 0;
    iss_rd0_en = 0; iss_rd0 = 0; iss_rd1_en = 0; iss_rd1 = 0;
    wb0_en = 0; wb0_addr = 0; wb1_en = 0; wb1_addr = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd0, input logic rd1_en, input logic [4:0] rd1);
    idle();
    iss_valid = 1; iss_rd0_en = 1; iss_rd0 = rd0; iss_rd1_en = rd1_en; iss_rd1 = rd1;
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;
    check("rst_busy", busy_mask, 32'h0);
    check("rst_stall", stall_cycles, 32'd0);
    check("rst_under", {31'd0, underflow_err}, 32'd1 - 32'd1);
    check("rst_ready", {31'd0, iss_ready}, 32'd1);

    // Independent instruction issues immediately.
    issue(5'd7, 1'b0, 5'd0);
    iss_rs1 = 5; iss_rs1_used = 1; iss_rs2 = 6; iss_rs2_used = 1;
    #1 check("t1_ready", {31'd0, iss_ready}, 32'd1);
    tick(); idle();
    check("t1_busy", busy_mask, 32'h80);
    check("t1_stall", stall_cycles, 32'd0);

    // RAW on r7: 3 stall cycles, writeback cycle still stalls, free next cycle.
    issue(5'd8, 1'b0, 5'd0);
    iss_rs1 = 7; iss_rs1_used = 1;
    for (int k = 0; k < 3; k++) begin
      #1 check("t2_raw_stall", {31'd0, iss_ready}, 32'd0);
      tick();
    end
    check("t2_stall3", stall_cycles, 32'd3);
    wb0_en = 1; wb0_addr = 7;
    #1 check("t2_no_bypass", {31'd0, iss_ready}, 32'd0);
    tick();
    wb0_en = 0;
    #1 check("t2_release", {31'd0, iss_ready}, 32'd1);
    check("t2_stall4", stall_cycles, 32'd4);
    tick(); idle();
    check("t2_busy_r8", busy_mask, 32'h100);
    wb1_en = 1; wb1_addr = 8;
    tick(); idle();
    check("t2_wb1_clr", busy_mask, 32'h0);

    // rd0 == rd1 claims once; a single writeback clears it.
    issue(5'd3, 1'b1, 5'd3);
    tick(); idle();
    check("t3_busy", busy_mask, 32'h8);
    wb0_en = 1; wb0_addr = 3;
    tick(); idle();
    check("t3_clear", busy_mask, 32'h0);
    check("t3_no_under", {31'd0, underflow_err}, 32'd0);

    // Writeback to r9 alongside an issue to r2.
    issue(5'd9, 1'b0, 5'd0);
    tick(); idle();
    check("t4_busy9", busy_mask, 32'h200);
    issue(5'd2, 1'b0, 5'd0);
    wb0_en = 1; wb0_addr = 9;
    #1 check("t4_ready", {31'd0, iss_ready}, 32'd1);
    tick(); idle();
    check("t4_busy2", busy_mask, 32'h4);
    // RAW on rs2 and WAW on rd1 against r2.
    iss_rs2 = 2; iss_rs2_used = 1;
    #1 check("t4_raw_rs2", {31'd0, iss_ready}, 32'd0);
    idle(); iss_rd1_en = 1; iss_rd1 = 2;
    #1 check("t4_waw_rd1", {31'd0, iss_ready}, 32'd0);
    idle(); wb0_en = 1; wb0_addr = 2; wb1_en = 1; wb1_addr = 2;
    tick(); idle();
    check("t4_dual_wb", busy_mask, 32'h0);
    check("t4_dual_no_under", {31'd0, underflow_err}, 32'd0);

    // Underflow on idle register.
    wb0_en = 1; wb0_addr = 12;
    tick(); idle();
    check("t5_under", {31'd0, underflow_err}, 32'd1);
    check("t5_busy", busy_mask, 32'h0);

    // Flush drops claims and blocks issue in the flush cycle.
    issue(5'd1, 1'b1, 5'd2);
    tick();
    issue(5'd31, 1'b0, 5'd0);
    tick(); idle();
    check("t6_claims", busy_mask, 32'h8000_0006);
    issue(5'd5, 1'b0, 5'd0);
    flush = 1;
    #1 check("t6_flush_ready", {31'd0, iss_ready}, 32'd0);
    tick(); idle();
    check("t6_flush_busy", busy_mask, 32'h0);
    check("t6_flush_stall", stall_cycles, 32'd5);
    check("t6_under_sticky", {31'd0, underflow_err}, 32'd1);

    // rd0 = r0 never marks bit 0.
    issue(5'd0, 1'b0, 5'd0);
    #1 check("t7_r0_ready", {31'd0, iss_ready}, 32'd1);
    tick(); idle();
    check("t7_r0_busy", busy_mask, 32'h0);

    // Reset mid-operation drops claims and clears sticky state.
    issue(5'd15, 1'b0, 5'd0);
    tick();
    check("t8_busy15", busy_mask, 32'h8000);
    issue(5'd16, 1'b0, 5'd0);
    rst = 1;
    tick();
    rst = 0; idle();
    check("t8_rst_busy", busy_mask, 32'h0);
    check("t8_rst_under", {31'd0, underflow_err}, 32'd0);
    check("t8_rst_stall", stall_cycles, 32'd0);
    iss_rs1 = 15; iss_rs1_used = 1; iss_rd0_en = 1; iss_rd0 = 16;
    #1 check("t8_free_after_rst", {31'd0, iss_ready}, 32'd1);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks in-flight register writes so the issue stage never reads or overwrites a register whose write is still pending.
- Sits between decode/issue and the two-write-port register file.
- Each issue may claim up to two destinations: a load/ALU result and a pre/post-increment address.
- The writeback ports release claims. The block asserts iss_ready only when an instruction is free of hazards.

Parameters:
- NREGS, 32, number of architectural registers; r0 is hardwired zero.
- CNT_W, 2, width of the per-register pending-write counter.
- STALL_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- iss_valid  input  1  decode presents an instruction
- iss_ready  output  1  instruction may issue this cycle (combinational from registered state)
- iss_rs1  input  5  source 1 address
- iss_rs1_used  input  1  source 1 is read
- iss_rs2  input  5  source 2 address
- iss_rs2_used  input  1  source 2 is read
- iss_rd0_en  input  1  primary destination claimed
- iss_rd0  input  5  primary destination address
- iss_rd1_en  input  1  secondary (address-update) destination claimed
- iss_rd1  input  5  secondary destination address
- wb0_en  input  1  write port 0 commits
- wb0_addr  input  5  write port 0 address
- wb1_en  input  1  write port 1 commits
- wb1_addr  input  5  write port 1 address
- flush  input  1  pipeline flush; drop all claims
- busy_mask  output  32  bit i = 1 when pend[i] != 0; registered
- stall_cycles  output  STALL_W  saturating count of cycles with iss_valid && !iss_ready
- underflow_err  output  1  sticky; a writeback hit a register with pend == 0

Behaviour:
- State: pend[1..NREGS-1], each CNT_W bits. Register r0 has no counter and is always not busy.
- Reset: all pend = 0, busy_mask = 0, stall_cycles = 0, underflow_err = 0. iss_ready = 1 once iss_valid is applied.
- Hazard conditions (all evaluated on registered pend, with no same-cycle writeback bypass):
  - RAW: rsN_used and rsN != 0 and pend[rsN] != 0.
  - WAW: rdN_en and rdN != 0 and pend[rdN] != 0.
  - Saturation: a claimed rd has pend equal to the maximum value.
- iss_ready = !flush && no hazard. iss_ready does not depend on iss_valid.
- Fire = iss_valid && iss_ready. On fire, pend[rd0] increments and pend[rd1] increments.
- If rd0_en and rd1_en both point to the same register, only one increment happens. The primary write wins, matching the regfile rule that port 1 is dropped when the addresses match.
- Writeback: wb0_en decrements pend[wb0_addr] and wb1_en decrements pend[wb1_addr].
  - wb0 and wb1 to the same address count as one decrement.
  - Address 0 is ignored.
- Same-cycle increment and decrement on one register net to zero change.
- Underflow: a decrement on pend == 0 leaves pend at 0 and sets underflow_err. underflow_err clears only on rst.
- Release timing: a register released by writeback in cycle N is seen as free by iss_ready in cycle N+1 (1-cycle release latency).
- flush:
  - Sets every pend to 0 next cycle.
  - Overrides fire and writeback in the same cycle.
  - Forces iss_ready to 0 during the flush cycle.
  - Does not clear stall_cycles or underflow_err.
- stall_cycles increments when iss_valid && !iss_ready, including flush cycles, and saturates at all-ones.
- busy_mask is updated each cycle from next-state pend. Bit 0 is always 0.
- rst has priority over flush, issue and writeback. Asserting rst mid-operation drops all claims in one cycle.

Test Plan:
- Reset, then iss_valid with rs1=5, rs2=6, rd0=7 → iss_ready=1. Next cycle busy_mask=0x80; stall_cycles=0.
- Issue rd0=7, then the next instruction uses rs1=7 → iss_ready=0 for each cycle until wb0 to r7. With wb0 to r7 in cycle N, iss_ready=1 in cycle N+1 and stall_cycles equals the stall count.
- Issue rd0=3, rd1=3 → pend[3]=1, not 2. A single wb0 to r3 clears busy_mask bit 3.
- Issue rd0=4 while wb1 to r4 arrives in the same cycle with pend[4]=1 is impossible: pend[4]=1 blocks on WAW. Instead, issue rd0=9, then in a later cycle apply wb0 to r9 together with an issue to rd0=2 → pend[9]=0 and pend[2]=1.
- wb0 to r12 with pend[12]=0 → underflow_err=1, busy_mask unchanged. underflow_err stays 1 after flush and clears only on rst.
- Claim r1, r2 and r31, then assert flush together with iss_valid → iss_ready=0 that cycle. Next cycle busy_mask=0 and nothing has issued. rd0=0 issues never set bit 0.
